manchester_encoder_100m: RTL and testbench

Downstream stage of the 100 MHz frame packer. It takes the packer's serial bit stream (tx_bit / tx_bit_valid / tx_bit_ready) and buffers it in a small bit FIFO. It then Manchester-encodes each bit onto the coax line driver: 25 Mbps data becomes 50 Mbaud at clk_sys = 100 MHz. It also drives line output-enable and reports status counters for the link monitor.

---
 rtl/manchester_encoder_100m.sv | 248 ++++++++++++++++++++++++
 tb/tb_manchester_encoder_100m.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_encoder_100m.sv
// manchester_encoder_100m
// Buffers the frame packer's serial bit stream in a small bit FIFO and
// Manchester-encodes it (IEEE 802.3: bit 1 = low then high, bit 0 = high then
// low) onto the coax line driver, with registered output-enable and status.
//
// Optional build macro MANCHESTER_PREAMBLE_EN: when defined, every burst is
// preceded by PREAMBLE_BITS encoded bits of 1,0,1,0,... (not counted in
// bit_count). When undefined, the preamble state and its counter do not exist.
module manchester_encoder_100m #(
  parameter int CLKS_PER_HALF = 2,
  parameter int BUF_DEPTH     = 4,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        tx_bit,
  input  logic        tx_bit_valid,
  output logic        tx_bit_ready,
  input  logic        clr_status,
  output logic        man_out,
  output logic        man_oe,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] bit_count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0]       HALF_LAST     = 4'(CLKS_PER_HALF - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] READY_MAX_CNT = CNT_W'(BUF_DEPTH - 2);

  // Reject illegal configurations at elaboration time.
  if (CLKS_PER_HALF < 1 || CLKS_PER_HALF > 15) begin : g_bad_half
    $error("CLKS_PER_HALF must be in 1..15");
  end
  if (BUF_DEPTH < 4 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BUF_DEPTH must be a power of two, at least 4");
  end
  if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 32) begin : g_bad_preamble
    $error("PREAMBLE_BITS must be in 1..32");
  end

`ifdef MANCHESTER_PREAMBLE_EN
  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PREAMBLE    = 2'd1,
    S_FIRST_HALF  = 2'd2,
    S_SECOND_HALF = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_FIRST_HALF  = 2'd2,
    S_SECOND_HALF = 2'd3
  } state_t;
`endif

  state_t           state;
  logic [3:0]       half_cnt;
  logic             cur_bit;
  logic             half_last;
  logic             bit_done;

  logic [BUF_DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic [CNT_W-1:0]     fifo_cnt_next;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 head_bit;
  logic                 push;
  logic                 pop;
  logic                 ovf_event;

`ifdef MANCHESTER_PREAMBLE_EN
  localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_BITS - 1);
  logic [4:0] pre_cnt;
  logic       pre_second;
  logic       pre_done;
`endif

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  assign head_bit   = fifo_mem[rd_ptr];
  assign half_last  = (half_cnt == HALF_LAST);
  assign bit_done   = (state == S_SECOND_HALF) && half_last;

  // The FIFO is never empty at the end of the preamble: nothing else pops
  // while the preamble runs, and it is only entered with the FIFO non-empty.
`ifdef MANCHESTER_PREAMBLE_EN
  assign pre_done = (state == S_PREAMBLE) && half_last && pre_second && (pre_cnt == PRE_LAST);
  assign pop      = pre_done || (bit_done && !fifo_empty);
`else
  assign pop      = ((state == S_IDLE) && !fifo_empty) || (bit_done && !fifo_empty);
`endif

  // The packer's valid is not qualified by ready; a simultaneous pop frees
  // a slot, so push-while-full is legal when the encoder pops that cycle.
  assign push          = tx_bit_valid && (!fifo_full || pop);
  assign ovf_event     = tx_bit_valid && fifo_full && !pop;
  assign fifo_cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

  assign busy = (state != S_IDLE) || !fifo_empty;

  // FIFO pointers, occupancy and the registered lookahead ready.
  // NOTE: every clocked register uses <= so all of them sample pre-edge values;
  // blocking = here would let later statements see already-updated state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      tx_bit_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt     <= fifo_cnt_next;
      // Leave room for the one bit the packer may already have in flight.
      tx_bit_ready <= (fifo_cnt_next <= READY_MAX_CNT);
    end
  end

  // Bit storage, written on push.
  // NOTE: the storage array is deliberately not reset; only entries between
  // the (reset) read and write pointers are ever observed.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= tx_bit;
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr_status) begin
      overflow <= ovf_event;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end
  end

  // Transmitted data-bit counter; a bit completing during a clear counts as 1.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_count <= '0;
    end else if (clr_status) begin
      bit_count <= bit_done ? 16'd1 : 16'd0;
    end else if (bit_done) begin
      bit_count <= bit_count + 16'd1;
    end
  end

  // Encoder FSM with registered line outputs; each half-level is loaded on
  // the same edge as the state change that starts it.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      half_cnt   <= '0;
      cur_bit    <= 1'b0;
      man_out    <= 1'b0;
      man_oe     <= 1'b0;
`ifdef MANCHESTER_PREAMBLE_EN
      pre_cnt    <= '0;
      pre_second <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          half_cnt <= '0;
          man_out  <= 1'b0;
          man_oe   <= 1'b0;
          if (!fifo_empty) begin
            man_oe <= 1'b1;
`ifdef MANCHESTER_PREAMBLE_EN
            // First preamble bit is a 1: low first half.
            state      <= S_PREAMBLE;
            pre_cnt    <= '0;
            pre_second <= 1'b0;
            man_out    <= 1'b0;
`else
            state   <= S_FIRST_HALF;
            cur_bit <= head_bit;
            man_out <= ~head_bit;
`endif
          end
        end

`ifdef MANCHESTER_PREAMBLE_EN
        S_PREAMBLE: begin
          if (!half_last) begin
            half_cnt <= half_cnt + 4'd1;
          end else begin
            half_cnt <= '0;
            // Current preamble bit is ~pre_cnt[0]; its second-half level and
            // the next bit's first-half level are both ~pre_cnt[0].
            if (!pre_second) begin
              pre_second <= 1'b1;
              man_out    <= ~pre_cnt[0];
            end else if (pre_cnt == PRE_LAST) begin
              state   <= S_FIRST_HALF;
              cur_bit <= head_bit;
              man_out <= ~head_bit;
            end else begin
              pre_cnt    <= pre_cnt + 5'd1;
              pre_second <= 1'b0;
              man_out    <= ~pre_cnt[0];
            end
          end
        end
`endif

        S_FIRST_HALF: begin
          if (!half_last) begin
            half_cnt <= half_cnt + 4'd1;
          end else begin
            half_cnt <= '0;
            state    <= S_SECOND_HALF;
            man_out  <= cur_bit;
          end
        end

        S_SECOND_HALF: begin
          if (!half_last) begin
            half_cnt <= half_cnt + 4'd1;
          end else begin
            half_cnt <= '0;
            if (!fifo_empty) begin
              // Back-to-back bits: no idle gap on the line.
              state   <= S_FIRST_HALF;
              cur_bit <= head_bit;
              man_out <= ~head_bit;
            end else begin
              state   <= S_IDLE;
              man_out <= 1'b0;
              man_oe  <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_encoder_100m.sv
// tb_manchester_encoder_100m
// Directed bench for manchester_encoder_100m with default parameters
// (CLKS_PER_HALF=2, BUF_DEPTH=4, PREAMBLE_BITS=8). Outputs are sampled on the
// falling edge; inputs are driven right after sampling.
`timescale 1ns/1ps
module tb_manchester_encoder_100m;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx_bit = 1'b0;
  logic        tx_bit_valid = 1'b0;
  logic        clr_status = 1'b0;
  logic        tx_bit_ready;
  logic        man_out;
  logic        man_oe;
  logic        busy;
  logic        overflow;
  logic [15:0] bit_count;

  int total = 0;
  int bad   = 0;

`ifdef MANCHESTER_PREAMBLE_EN
  localparam int          LEAD       = 32;
  localparam logic [63:0] PRE_O      = 64'h3C3C_3C3C;
  localparam logic [63:0] PRE_OE     = 64'hFFFF_FFFF;
  localparam int          OVF_LEVELS = 60;
  localparam logic [63:0] OVF_O      = {4'h0, 32'h3C3C_3C3C, 16'h3C33, 12'h000};
  localparam logic [63:0] OVF_OE     = {4'h0, 48'hFFFF_FFFF_FFFF, 12'h000};
  localparam int          OVF_BITS   = 4;
  localparam int          OVF2_BITS  = 4;
`else
  localparam int          LEAD       = 0;
  localparam logic [63:0] PRE_O      = 64'h0;
  localparam logic [63:0] PRE_OE     = 64'h0;
  localparam int          OVF_LEVELS = 28;
  localparam logic [63:0] OVF_O      = {36'h0, 24'h3C_33C3, 4'h0};
  localparam logic [63:0] OVF_OE     = {36'h0, 24'hFF_FFFF, 4'h0};
  localparam int          OVF_BITS   = 6;
  localparam int          OVF2_BITS  = 5;
`endif

  manchester_encoder_100m #(
    .CLKS_PER_HALF(2),
    .BUF_DEPTH    (4),
    .PREAMBLE_BITS(8)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .tx_bit      (tx_bit),
    .tx_bit_valid(tx_bit_valid),
    .tx_bit_ready(tx_bit_ready),
    .clr_status  (clr_status),
    .man_out     (man_out),
    .man_oe      (man_oe),
    .busy        (busy),
    .overflow    (overflow),
    .bit_count   (bit_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Strobe one bit into an idle block and record LEAD+8 line levels starting
  // two cycles after the strobe. clr_status is pulsed on iteration clr_at.
  task automatic send_one(input logic b, input int clr_at, output logic [63:0] o, output logic [63:0] e);
    o = '0;
    e = '0;
    for (int k = 0; k < LEAD + 10; k++) begin
      @(negedge clk_sys);
      if (k >= 2) begin
        o = {o[62:0], man_out};
        e = {e[62:0], man_oe};
      end
      tx_bit_valid = (k == 0);
      tx_bit       = b;
      clr_status   = (k == clr_at);
    end
    tx_bit_valid = 1'b0;
    clr_status   = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk_sys);
    clr_status = 1'b1;
    @(negedge clk_sys);
    clr_status = 1'b0;
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #200us;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0]  o;
    logic [63:0]  e;
    logic [255:0] got_o;
    logic [255:0] got_e;
    logic [255:0] exp_o;
    logic [255:0] exp_e;
    logic [55:0]  frame;
    logic [7:0]   ovf_pat;
    int           bit_idx;
    logic         ovf_seen;

    frame   = 56'hAA_00_DEAD_BEEF_5C;
    ovf_pat = 8'b1011_0110;

    // ---- reset ----
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", {tx_bit_ready, man_out, man_oe, busy, overflow, bit_count}, 21'h0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("ready_after_release", tx_bit_ready, 1'b1);
    check("idle_after_release", {man_out, man_oe, busy}, 3'b000);

    // ---- single bit 1: levels 0,0,1,1 then idle ----
    send_one(1'b1, -1, o, e);
    check("bit1_man_out", o, (PRE_O << 8) | 64'h30);
    check("bit1_man_oe", e, (PRE_OE << 8) | 64'hF0);
    check("bit1_count", bit_count, 16'd1);

    // ---- single bit 0: levels 1,1,0,0 then idle ----
    send_one(1'b0, -1, o, e);
    check("bit0_man_out", o, (PRE_O << 8) | 64'hC0);
    check("bit0_man_oe", e, (PRE_OE << 8) | 64'hF0);
    check("bit0_count", bit_count, 16'd2);
    check("bit0_idle", {man_out, man_oe, busy}, 3'b000);

    pulse_clr();
    check("clr_count", bit_count, 16'd0);

    // ---- 56-bit frame driven by a ready-following packer ----
    bit_idx  = 0;
    ovf_seen = 1'b0;
    got_o    = '0;
    got_e    = '0;
    for (int k = 0; k < LEAD + 226; k++) begin
      @(negedge clk_sys);
      if (k >= LEAD + 2) begin
        got_o = {got_o[254:0], man_out};
        got_e = {got_e[254:0], man_oe};
      end
      if (overflow) ovf_seen = 1'b1;
      if (tx_bit_ready && bit_idx < 56) begin
        tx_bit_valid = 1'b1;
        tx_bit       = frame[55 - bit_idx];
        bit_idx++;
      end else begin
        tx_bit_valid = 1'b0;
      end
    end
    tx_bit_valid = 1'b0;
    exp_o = '0;
    for (int i = 0; i < 56; i++) begin
      exp_o[223 - 4*i -: 4] = {~frame[55 - i], ~frame[55 - i], frame[55 - i], frame[55 - i]};
    end
    exp_e = '0;
    exp_e[223:0] = '1;
    check("frame_man_out", got_o, exp_o);
    check("frame_man_oe", got_e, exp_e);
    check("frame_no_overflow", ovf_seen, 1'b0);
    @(negedge clk_sys);
    check("frame_count", bit_count, 16'd56);
    check("frame_idle", {man_oe, busy}, 2'b00);

    // ---- overflow: valid forced high for 8 cycles ----
    pulse_clr();
    o = '0;
    e = '0;
    for (int k = 0; k < OVF_LEVELS + 2; k++) begin
      @(negedge clk_sys);
      if (k >= 2) begin
        o = {o[62:0], man_out};
        e = {e[62:0], man_oe};
      end
      tx_bit_valid = (k < 8);
      if (k < 8) tx_bit = ovf_pat[7 - k];
    end
    tx_bit_valid = 1'b0;
    check("ovf_flag", overflow, 1'b1);
    check("ovf_man_out", o, OVF_O);
    check("ovf_man_oe", e, OVF_OE);
    check("ovf_count", bit_count, 16'(OVF_BITS));

    // ---- clear alone ----
    pulse_clr();
    check("clr_overflow", {overflow, bit_count}, 17'h0);

    // ---- clear coinciding with an overflow drop ----
    o = '0;
    e = '0;
    for (int k = 0; k < OVF_LEVELS + 2; k++) begin
      @(negedge clk_sys);
      if (k >= 2) begin
        o = {o[62:0], man_out};
        e = {e[62:0], man_oe};
      end
      if (k == 8) begin
        check("ovf_clr_coincide_flag", overflow, 1'b1);
        check("ovf_clr_coincide_count", bit_count, 16'd0);
      end
      tx_bit_valid = (k < 8);
      if (k < 8) tx_bit = ovf_pat[7 - k];
      clr_status = (k == 7);
    end
    tx_bit_valid = 1'b0;
    clr_status   = 1'b0;
    check("ovf2_man_out", o, OVF_O);
    check("ovf2_count", bit_count, 16'(OVF2_BITS));

    // ---- asynchronous reset in the middle of a bit ----
    @(negedge clk_sys);
    tx_bit_valid = 1'b1;
    tx_bit       = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    @(negedge clk_sys);
    tx_bit_valid = 1'b0;
    @(negedge clk_sys);
    check("pre_reset_line", {man_out, man_oe}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {tx_bit_ready, man_out, man_oe, busy, overflow, bit_count}, 21'h0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("post_reset_flushed", {tx_bit_ready, busy, man_oe}, 3'b100);
    send_one(1'b0, -1, o, e);
    check("post_reset_man_out", o, (PRE_O << 8) | 64'hC0);
    check("post_reset_count", bit_count, 16'd1);

    // ---- clear coinciding with a bit completion ----
    send_one(1'b1, LEAD + 5, o, e);
    check("clr_inc_man_out", o, (PRE_O << 8) | 64'h30);
    check("clr_inc_count", bit_count, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
